// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared constants and FSM encoding for the multiply/divide unit
// Revision   : 1.0
// ============================================================================
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// muldiv_if : request/response bundle between the issuing core and muldiv_unit
// Revision  : 1.0
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
) ();

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative signed multiply (radix-2 Booth) / restoring divide
// Revision    : 1.0
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH:0]     prod_q, prod_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dz_q, dz_d;

    logic [WIDTH:0]       booth_acc, booth_mcand, booth_sum;
    logic [2*WIDTH:0]     booth_next;

    logic [WIDTH-1:0]     div_bmag;
    logic [WIDTH+1:0]     div_shift, div_diff;
    logic                 div_qbit;
    logic [WIDTH:0]       rem_next;
    logic [WIDTH-1:0]     quo_next;
    logic [WIDTH-1:0]     quo_res, rem_res;
    logic                 last_step;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Booth step: the add is done one bit wider so subtracting the most-negative
    // multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        booth_acc   = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
        booth_mcand = {a_q[WIDTH-1], a_q};
        case (prod_q[1:0])
            2'b01:   booth_sum = booth_acc + booth_mcand;
            2'b10:   booth_sum = booth_acc - booth_mcand;
            default: booth_sum = booth_acc;
        endcase
        booth_next = {booth_sum, prod_q[WIDTH:1]};
    end

    always_comb begin
        div_bmag  = magnitude(b_q);
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {2'b00, div_bmag};
        div_qbit  = ~div_diff[WIDTH+1];
        rem_next  = div_qbit ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
        quo_next  = {quo_q[WIDTH-2:0], div_qbit};
        quo_res   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_next : quo_next;
        rem_res   = a_q[WIDTH-1] ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    a_d   = bus.a;
                    b_d   = bus.b;
                    cnt_d = '0;
                    if (bus.op == OP_MULT) begin
                        state_d = MULT;
                        prod_d  = {{WIDTH{1'b0}}, bus.b, 1'b0};
                    end else if (bus.b == '0) begin
                        state_d = FINISH;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = DIV;
                        rem_d   = '0;
                        quo_d   = magnitude(bus.a);
                    end
                end
            end
            MULT: begin
                prod_d = booth_next;
                cnt_d  = cnt_q + CW'(1);
            end
            DIV: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + CW'(1);
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Results are committed only on the edge that enters FINISH.
        last_step = ((state_q == MULT) || (state_q == DIV)) && (cnt_q == LAST_STEP);
        if (last_step) begin
            state_d = FINISH;
            hi_d    = (op_q == OP_MULT) ? booth_next[2*WIDTH:WIDTH+1] : rem_res;
            lo_d    = (op_q == OP_MULT) ? booth_next[WIDTH:1]         : quo_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == FINISH);
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL: parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL: start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL: op  input  1  operation select (0 = signed multiply, 1 = signed divide).
REQ-006 SHALL: a  input  WIDTH  multiplicand or dividend (two's complement).
REQ-007 SHALL: b  input  WIDTH  multiplier or divisor (two's complement).
REQ-008 SHALL: busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL: done  output  1  one-cycle completion pulse.
REQ-010 SHALL: div_zero  output  1  one-cycle pulse with done when a divide had b == 0.
REQ-011 SHALL: hi  output  WIDTH  multiply: upper product half; divide: remainder; feeds the write-back select mux.
REQ-012 SHALL: lo  output  WIDTH  multiply: lower product half; divide: quotient; feeds the write-back select mux.

Function
REQ-013 SHALL: FSM states are IDLE, MULT, DIV and FINISH, with done = (state == FINISH).
REQ-014 SHALL: in IDLE with start=1, latch a, b and op, then go to MULT (op=0), to DIV (op=1, b≠0), or directly to FINISH (op=1, b=0).
REQ-015 SHALL: ignore start in every state except IDLE, with no effect on the operation in flight.
REQ-016 SHALL: MULT performs radix-2 Booth, one step per cycle for exactly WIDTH steps, then enters FINISH; the product is the full 2*WIDTH-bit signed product.
REQ-017 SHALL: DIV performs restoring division on operand magnitudes, one step per cycle for exactly WIDTH steps, then enters FINISH.
REQ-018 SHALL: divide sign rule: quotient is negative iff operand signs differ; remainder takes the sign of the dividend; quotient truncates toward zero.
REQ-019 SHALL: most-negative / -1 yields lo = most-negative value (wrap) and hi = 0, with no flag.
REQ-020 SHALL: latency: for MULT and DIV (b≠0), done is high in the cycle after the (WIDTH+1)th rising edge counted from the start-sampling edge; for divide-by-zero, done is high in the cycle after the start-sampling edge.
REQ-021 SHALL: hi and lo update only on the edge entering FINISH and hold that value until the next completed operation.
REQ-022 SHALL: divide-by-zero leaves hi and lo unchanged and asserts div_zero together with done.
REQ-023 SHALL: FINISH lasts exactly one cycle and always returns to IDLE; start in that cycle is ignored.
REQ-024 SHALL: all arithmetic is two's complement; internal accumulators are 2*WIDTH+1 bits for MULT and WIDTH+1 bits for the DIV partial remainder.

Reset
REQ-025 SHALL: reset=1 forces state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, and clears the iteration counter and operand registers.
REQ-026 SHALL: reset asserted mid-operation aborts the operation; no done pulse is produced and hi/lo read 0.
REQ-027 SHALL: reset takes priority over start on the same edge.

Structure
REQ-028 SHALL: a shared package muldiv_pkg holds the state encoding, the op encodings (OP_MULT=0, OP_DIV=1) and the default width constant.
REQ-029 SHALL: the block is a single module with one FSM and one shared iteration counter, and no sub-module.

Verification
REQ-030 SHALL: MULT a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly per REQ-020 (33rd edge), busy high throughout.
REQ-031 SHALL: MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-032 SHALL: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
REQ-033 SHALL: DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> done and div_zero high in the cycle after the start edge, hi=0x11, lo=0x22 unchanged.
REQ-034 SHALL: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-035 SHALL: MULT started, start re-pulsed at step 5 with new operands, reset asserted at step 10 -> no done pulse, state IDLE, hi=lo=0; a following MULT 3*4 gives lo=12, hi=0.
